avalonmm_to_st_packet_fifo: RTL and testbench
=============================================

// Module: avalonmm_to_st_packet_fifo
// PURPOSE
//  Parametrised Avalon-MM write slave to Avalon-ST packet source FIFO, next generation of the h2f input FIFO.
//  HPS writes sideband (sop/eop/empty) then data words; words stream out with per-word packet sideband.
//  Adds: generic width/depth, ready backpressure on source, waitrequest or drop-with-overflow on full,
//  readable status/fill-level register. Single clock domain; inferred RAM, no vendor FIFO macro.
// PARAMETERS
//  DATA_WIDTH    32  data word width; multiple of SYMBOL_WIDTH, <=64
//  SYMBOL_WIDTH  8   symbol width for byte-swap and empty count
//  DEPTH         8   word capacity, power of 2, >=4
//  BYTE_SWAP     1   1: reverse symbol order MM->ST (MM symbol 0 -> ST MSB symbol); 0: pass-through
//  BACKPRESSURE  1   1: stall MM writes to data addr when full; 0: drop them, set overflow flag
//  (local) AW=log2(DEPTH), EW=log2(DATA_WIDTH/SYMBOL_WIDTH)
// PORTS
//  wrclock                        in   1           sole clock
//  reset                          in   1           asynchronous, active-high reset
//  avalonmm_write_slave_address   in   2           0=data, 1=other-info, 2=status, 3=reserved
//  avalonmm_write_slave_write     in   1           write strobe
//  avalonmm_write_slave_writedata in   DATA_WIDTH  write data
//  avalonmm_write_slave_read      in   1           read strobe
//  avalonmm_write_slave_readdata  out  32          read data, fixed latency 1
//  avalonmm_write_slave_waitrequest out 1          stall (BACKPRESSURE=1 only, else tied 0)
//  avalonst_source_data           out  DATA_WIDTH  stream data
//  avalonst_source_valid          out  1           word presented
//  avalonst_source_ready          in   1           sink accepts (readyLatency 0)
//  avalonst_source_startofpacket  out  1           sop of presented word
//  avalonst_source_endofpacket    out  1           eop of presented word
//  avalonst_source_empty          out  EW          empty symbols of presented word
// BEHAVIOUR
//  Reset: all outputs 0, fill 0, other-info reg 0, overflow 0; applies immediately, any cycle, drops contents.
//  Other-info write (addr 1): sop<=wd[0], eop<=wd[1], empty<=wd[2+:EW]; other bits ignored.
//  Data write (addr 0) accepted when fill<DEPTH: word (swapped per BYTE_SWAP) and {empty,eop,sop}
//   pushed together in one entry; same cycle sop/eop auto-clear, empty is held.
//  Simultaneous addr-1 write impossible (single port); accepted push clears sop/eop even if reg written earlier same packet.
//  Full (fill==DEPTH), data write: BACKPRESSURE=1 -> waitrequest=1 combinationally until a pop frees space,
//   write completes on first cycle with fill<DEPTH; BACKPRESSURE=0 -> word dropped, sop/eop NOT cleared, overflow<=1.
//  No full bypass: pop and push in same cycle at fill==DEPTH -> pop only, push waits/drops.
//  waitrequest is 0 for all other addresses and for reads.
//  Source: show-ahead; valid=1 iff fill>0; pop on valid&ready; data/sideband stable while valid&!ready.
//  Latency: push accepted at edge N -> valid=1 after edge N (empty FIFO), i.e. visible cycle N+1.
//  Push+pop same cycle with 0<fill<DEPTH: fill unchanged, order preserved.
//  Pointers AW bits, wrap modulo DEPTH; fill AW+1 bits, range 0..DEPTH.
//  Status (addr 2 read): [AW:0]=fill, [16]=full, [17]=fifo empty, [18]=overflow, rest 0.
//  Write addr 2 with wd[18]=1 clears overflow; overflow set in same cycle wins.
//  Read addr 0/1: returns other-info reg {empty,eop,sop} in [2+EW-1:0] for addr 1, 0 for addr 0/3.
//  readdata registered: valid cycle after read strobe, holds otherwise.
// TESTING
//  1 Write addr1=0x1, data A,B; addr1=0x6 (eop,empty=1), data C; ready=1 -> A(sop=1),B,C(eop=1,empty=1), A valid cycle after push.
//  2 BYTE_SWAP=1: write 0x11223344 -> source_data 0x44332211; BYTE_SWAP=0 -> 0x11223344.
//  3 BACKPRESSURE=1, ready=0, 9 writes, DEPTH=8 -> 9th holds waitrequest=1; one pop -> 9th accepted next cycle, status fill=8.
//  4 BACKPRESSURE=0, 9 writes to full FIFO -> 9th dropped, status[18]=1, fill=8; write addr2 0x40000 -> [18]=0.
//  5 fill=3, push+pop every cycle for 20 cycles with ready toggling -> fill stays 3, sequence intact across pointer wrap.
//  6 Assert reset mid-packet with fill=5, valid=1 -> valid=0 same cycle, status reads fill=0 after release.

Source files
------------

// File: rtl/avalonmm_to_st_packet_fifo.sv
// Avalon-MM write slave feeding an Avalon-ST packet source through a show-ahead FIFO.
// Sideband is latched from the other-info register and stored alongside each data word.
module avalonmm_to_st_packet_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BYTE_SWAP    = 1,
  parameter int unsigned BACKPRESSURE = 1,
  localparam int unsigned NSYM = DATA_WIDTH / SYMBOL_WIDTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned EW   = (NSYM > 1) ? $clog2(NSYM) : 1
) (
  input  logic                  wrclock,
  input  logic                  reset,
  input  logic [1:0]            avalonmm_write_slave_address,
  input  logic                  avalonmm_write_slave_write,
  input  logic [DATA_WIDTH-1:0] avalonmm_write_slave_writedata,
  input  logic                  avalonmm_write_slave_read,
  output logic [31:0]           avalonmm_write_slave_readdata,
  output logic                  avalonmm_write_slave_waitrequest,
  output logic [DATA_WIDTH-1:0] avalonst_source_data,
  output logic                  avalonst_source_valid,
  input  logic                  avalonst_source_ready,
  output logic                  avalonst_source_startofpacket,
  output logic                  avalonst_source_endofpacket,
  output logic [EW-1:0]         avalonst_source_empty
);

  localparam int unsigned EntW = DATA_WIDTH + EW + 2;

  logic [EntW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           fill_q, fill_d;
  logic                  sop_q, sop_d, eop_q, eop_d, ovf_q, ovf_d;
  logic [EW-1:0]         empty_q, empty_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] swapped;
  logic [EntW-1:0]       rd_entry;
  logic                  full, fifo_empty, data_wr, push, pop, drop, clr_ovf;

  assign full       = (fill_q == (AW+1)'(DEPTH));
  assign fifo_empty = (fill_q == '0);
  assign data_wr    = avalonmm_write_slave_write && (avalonmm_write_slave_address == 2'd0);
  assign push       = data_wr && !full;
  assign pop        = !fifo_empty && avalonst_source_ready;
  assign drop       = data_wr && full && (BACKPRESSURE == 0);

  assign avalonmm_write_slave_waitrequest = (BACKPRESSURE != 0) && data_wr && full;

  generate
    if (DATA_WIDTH > 18) begin : g_clr
      assign clr_ovf = avalonmm_write_slave_writedata[18];
    end else begin : g_no_clr
      assign clr_ovf = 1'b0;
    end
  endgenerate

  // MM symbol 0 lands in the ST most-significant symbol when swapping.
  always_comb begin
    swapped = avalonmm_write_slave_writedata;
    if (BYTE_SWAP != 0) begin
      for (int i = 0; i < NSYM; i++) begin
        swapped[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
          avalonmm_write_slave_writedata[(NSYM-1-i)*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    empty_d  = empty_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
    if (avalonmm_write_slave_write && avalonmm_write_slave_address == 2'd1) begin
      sop_d   = avalonmm_write_slave_writedata[0];
      eop_d   = avalonmm_write_slave_writedata[1];
      empty_d = avalonmm_write_slave_writedata[2 +: EW];
    end else if (push) begin
      sop_d = 1'b0;
      eop_d = 1'b0;
    end
    if (avalonmm_write_slave_write && avalonmm_write_slave_address == 2'd2 && clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) ovf_d = 1'b1;
    if (avalonmm_write_slave_read) begin
      rdata_d = '0;
      case (avalonmm_write_slave_address)
        2'd1: rdata_d = 32'({empty_q, eop_q, sop_q});
        2'd2: begin
          rdata_d[AW:0] = fill_q;
          rdata_d[16]   = full;
          rdata_d[17]   = fifo_empty;
          rdata_d[18]   = ovf_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      empty_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is not reset; outputs are gated by valid instead.
  always_ff @(posedge wrclock) begin
    if (push) mem_q[wr_ptr_q] <= {empty_q, eop_q, sop_q, swapped};
  end

  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    avalonst_source_valid         = !fifo_empty;
    avalonst_source_data          = '0;
    avalonst_source_startofpacket = 1'b0;
    avalonst_source_endofpacket   = 1'b0;
    avalonst_source_empty         = '0;
    if (!fifo_empty) begin
      avalonst_source_data          = rd_entry[DATA_WIDTH-1:0];
      avalonst_source_startofpacket = rd_entry[DATA_WIDTH];
      avalonst_source_endofpacket   = rd_entry[DATA_WIDTH+1];
      avalonst_source_empty         = rd_entry[DATA_WIDTH+2 +: EW];
    end
  end

  assign avalonmm_write_slave_readdata = rdata_q;

endmodule

// File: tb/tb_avalonmm_to_st_packet_fifo.sv
// Bench for avalonmm_to_st_packet_fifo: instance 0 swaps and backpressures,
// instance 1 passes through and drops on full. Stream output is scoreboarded.
module tb_avalonmm_to_st_packet_fifo;

  logic        clk, reset;
  logic [1:0]  addr [2];
  logic        write [2], read [2], waitreq [2], valid [2], ready [2], sop [2], eop [2];
  logic [31:0] wdata [2], rdata [2], data [2];
  logic [1:0]  emp [2];

  logic [35:0] q0 [$];
  logic [35:0] q1 [$];
  logic        sop_m [2], eop_m [2];
  logic [1:0]  emp_m [2];
  int          fill_m [2];
  int          n_cmp = 0, n_err = 0;
  logic [35:0] e0, e1;
  logic [31:0] v;

  avalonmm_to_st_packet_fifo #(
    .DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(8), .BYTE_SWAP(1), .BACKPRESSURE(1)
  ) dut (
    .wrclock                         (clk),
    .reset                           (reset),
    .avalonmm_write_slave_address    (addr[0]),
    .avalonmm_write_slave_write      (write[0]),
    .avalonmm_write_slave_writedata  (wdata[0]),
    .avalonmm_write_slave_read       (read[0]),
    .avalonmm_write_slave_readdata   (rdata[0]),
    .avalonmm_write_slave_waitrequest(waitreq[0]),
    .avalonst_source_data            (data[0]),
    .avalonst_source_valid           (valid[0]),
    .avalonst_source_ready           (ready[0]),
    .avalonst_source_startofpacket   (sop[0]),
    .avalonst_source_endofpacket     (eop[0]),
    .avalonst_source_empty           (emp[0])
  );

  avalonmm_to_st_packet_fifo #(
    .DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(8), .BYTE_SWAP(0), .BACKPRESSURE(0)
  ) dut_nb (
    .wrclock                         (clk),
    .reset                           (reset),
    .avalonmm_write_slave_address    (addr[1]),
    .avalonmm_write_slave_write      (write[1]),
    .avalonmm_write_slave_writedata  (wdata[1]),
    .avalonmm_write_slave_read       (read[1]),
    .avalonmm_write_slave_readdata   (rdata[1]),
    .avalonmm_write_slave_waitrequest(waitreq[1]),
    .avalonst_source_data            (data[1]),
    .avalonst_source_valid           (valid[1]),
    .avalonst_source_ready           (ready[1]),
    .avalonst_source_startofpacket   (sop[1]),
    .avalonst_source_endofpacket     (eop[1]),
    .avalonst_source_empty           (emp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int s = 0; s < 2; s++) begin
      sop_m[s] = 1'b0; eop_m[s] = 1'b0; emp_m[s] = 2'd0; fill_m[s] = 0;
    end
  endtask

  // One MM write; entered and left at posedge+1, holds while waitrequest is high.
  task automatic wr(input int s, input logic [1:0] a, input logic [31:0] d);
    int  n;
    logic [35:0] ent;
    n = 0;
    addr[s] = a; wdata[s] = d; write[s] = 1'b1;
    @(negedge clk);
    while (waitreq[s] === 1'b1) begin
      n++;
      if (n > 200) begin
        check("wait_timeout", 64'(waitreq[s]), 64'd0);
        break;
      end
      @(negedge clk);
    end
    if (a == 2'd1) begin
      sop_m[s] = d[0]; eop_m[s] = d[1]; emp_m[s] = d[3:2];
    end else if (a == 2'd0 && (s == 0 || fill_m[s] < 8)) begin
      ent = {sop_m[s], eop_m[s], emp_m[s], (s == 0) ? bswap(d) : d};
      if (s == 0) q0.push_back(ent); else q1.push_back(ent);
      fill_m[s]++;
      sop_m[s] = 1'b0; eop_m[s] = 1'b0;
    end
    @(posedge clk); #1;
    write[s] = 1'b0;
  endtask

  task automatic rd(input int s, input logic [1:0] a, output logic [31:0] val);
    addr[s] = a; read[s] = 1'b1;
    @(posedge clk); #1;
    read[s] = 1'b0;
    @(negedge clk);
    val = rdata[s];
    @(posedge clk); #1;
  endtask

  task automatic drain(input int s);
    int n;
    n = 0;
    ready[s] = 1'b1;
    while (((s == 0) ? q0.size() : q1.size()) > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    ready[s] = 1'b0;
    check("drain_left", 64'((s == 0) ? q0.size() : q1.size()), 64'd0);
    check("drain_valid", 64'(valid[s]), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid[0] === 1'b1 && ready[0] === 1'b1) begin
        if (q0.size() == 0) check("st0_unexpected", 64'(valid[0]), 64'd0);
        else begin
          e0 = q0.pop_front();
          check("st0_word", 64'({sop[0], eop[0], emp[0], data[0]}), 64'(e0));
        end
        fill_m[0]--;
      end
      if (valid[1] === 1'b1 && ready[1] === 1'b1) begin
        if (q1.size() == 0) check("st1_unexpected", 64'(valid[1]), 64'd0);
        else begin
          e1 = q1.pop_front();
          check("st1_word", 64'({sop[1], eop[1], emp[1], data[1]}), 64'(e1));
        end
        fill_m[1]--;
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      addr[s] = 2'd0; write[s] = 1'b0; read[s] = 1'b0; wdata[s] = '0; ready[s] = 1'b0;
    end
    model_reset();
    #3;
    check("rst_valid", 64'(valid[0]), 64'd0);
    check("rst_rdata", 64'(rdata[0]), 64'd0);
    check("rst_wait", 64'(waitreq[0]), 64'd0);
    check("rst_data", 64'(data[0]), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Packet with sideband; first word visible right after its push edge.
    ready[0] = 1'b1;
    wr(0, 2'd1, 32'h1);
    check("t1_idle_valid", 64'(valid[0]), 64'd0);
    wr(0, 2'd0, 32'hA0A1A2A3);
    check("t1_latency_valid", 64'(valid[0]), 64'd1);
    check("t1_first_data", 64'(data[0]), 64'(bswap(32'hA0A1A2A3)));
    check("t1_first_sop", 64'(sop[0]), 64'd1);
    wr(0, 2'd0, 32'hB0B1B2B3);
    wr(0, 2'd1, 32'h6);
    wr(0, 2'd0, 32'hC0C1C2C3);
    drain(0);
    rd(0, 2'd1, v);
    check("t1_info_held_empty", 64'(v), 64'h4);

    // Symbol order with and without swapping.
    wr(0, 2'd1, 32'h0);
    wr(0, 2'd0, 32'h11223344);
    check("t2_swap", 64'(data[0]), 64'h44332211);
    drain(0);
    wr(1, 2'd0, 32'h11223344);
    check("t2_noswap", 64'(data[1]), 64'h11223344);
    drain(1);

    // Backpressure: ninth write stalls until one pop frees a slot.
    for (int i = 0; i < 8; i++) wr(0, 2'd0, 32'h3000_0000 + i);
    fork
      wr(0, 2'd0, 32'h3000_0008);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t3_waitrequest", 64'(waitreq[0]), 64'd1);
        @(posedge clk); #1;
        ready[0] = 1'b1;
        @(posedge clk); #1;
        ready[0] = 1'b0;
      end
    join
    rd(0, 2'd2, v);
    check("t3_status_full", 64'(v), 64'h10008);
    drain(0);

    // Drop on full, sticky overflow, sideband kept on drop, overflow clear.
    for (int i = 0; i < 8; i++) wr(1, 2'd0, 32'h4000_0000 + i);
    wr(1, 2'd1, 32'h3);
    wr(1, 2'd0, 32'h4000_0008);
    check("t4_no_wait", 64'(waitreq[1]), 64'd0);
    rd(1, 2'd1, v);
    check("t4_info_kept", 64'(v), 64'h3);
    rd(1, 2'd2, v);
    check("t4_status_ovf", 64'(v), 64'h50008);
    wr(1, 2'd2, 32'h40000);
    rd(1, 2'd2, v);
    check("t4_status_clr", 64'(v), 64'h10008);
    rd(1, 2'd0, v);
    check("t4_read_addr0", 64'(v), 64'h0);
    wr(1, 2'd1, 32'h0);
    drain(1);

    // Steady fill of 3 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 3; i++) wr(0, 2'd0, 32'h5000_0000 + i);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 != 2) begin
        ready[0] = 1'b1;
        wr(0, 2'd0, 32'h5100_0000 + i);
        ready[0] = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    rd(0, 2'd2, v);
    check("t5_fill_steady", 64'(v), 64'h3);

    // Reset mid-packet at fill 5.
    wr(0, 2'd1, 32'h1);
    wr(0, 2'd0, 32'h6000_0000);
    wr(0, 2'd0, 32'h6000_0001);
    rd(0, 2'd2, v);
    check("t6_fill5", 64'(v), 64'h5);
    check("t6_valid_before", 64'(valid[0]), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_valid_async", 64'(valid[0]), 64'd0);
    check("t6_data_async", 64'(data[0]), 64'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    rd(0, 2'd2, v);
    check("t6_status_after", 64'(v), 64'h20000);
    rd(0, 2'd1, v);
    check("t6_info_after", 64'(v), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
